// File: rtl/aes_enc_iter.sv
// Iterative AES encryption engine: one round per clock on a shared round datapath,
// NR = 10/12/14, valid/ready handshakes on the plaintext input and ciphertext output.
module aes_enc_iter #(
   parameter int NR = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          plain_text,
   input  logic [128*(NR+1)-1:0] round_keys,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          cipher_text,
   output logic                  busy,
   output logic [3:0]            round_cnt
);

   generate
      if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
         $error("aes_enc_iter: NR must be 10, 12 or 14");
      end
   endgenerate

   localparam logic [3:0] NR4 = 4'(NR);

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t         state, state_nx;
   logic [127:0]   st, st_nx;
   logic [3:0]     rc, rc_nx;
   logic [127:0]   ct_nx;
   logic           ov_nx;
   logic [127:0]   rk_sel;
   logic [127:0]   sr, mc, full_rnd, final_rnd;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte k lives at bits [127-8k -: 8]; byte r+4c is row r, column c.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   always_comb begin
      rk_sel = '0;
      for (int i = 1; i <= NR; i++)
         if (rc == 4'(i)) rk_sel = round_keys[128*i +: 128];
   end

   assign sr        = sub_shift(st);
   assign mc        = mix_cols(sr);
   assign full_rnd  = mc ^ rk_sel;
   assign final_rnd = sr ^ rk_sel;

   // Ready never looks at in_valid, so no in_valid -> in_ready path exists.
   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign busy      = (state != IDLE);
   assign round_cnt = rc;

   always_comb begin
      state_nx = state;
      st_nx    = st;
      rc_nx    = rc;
      ct_nx    = cipher_text;
      ov_nx    = out_valid;
      case (state)
         IDLE: begin
            if (in_valid) begin
               st_nx    = plain_text ^ round_keys[127:0];
               rc_nx    = 4'd1;
               state_nx = ROUND;
            end
         end
         ROUND: begin
            if (rc == NR4) begin
               ct_nx    = final_rnd;
               ov_nx    = 1'b1;
               rc_nx    = 4'd0;
               state_nx = DONE;
            end else begin
               st_nx = full_rnd;
               rc_nx = rc + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_nx = 1'b0;
               if (in_valid) begin
                  st_nx    = plain_text ^ round_keys[127:0];
                  rc_nx    = 4'd1;
                  state_nx = ROUND;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            rc_nx    = 4'd0;
            ov_nx    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         st          <= '0;
         rc          <= '0;
         cipher_text <= '0;
         out_valid   <= 1'b0;
      end else begin
         state       <= state_nx;
         st          <= st_nx;
         rc          <= rc_nx;
         cipher_text <= ct_nx;
         out_valid   <= ov_nx;
      end
   end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: byte-level AES reference model with
// arithmetic S-box and key expansion, randomized blocks and keys.
module tb_aes_enc_iter;
   parameter int NR = 10;
   localparam int RKW = 128*(NR+1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [127:0]   plain_text = '0;
   logic [RKW-1:0] round_keys = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [127:0]   cipher_text;
   logic           busy;
   logic [3:0]     round_cnt;

   aes_enc_iter #(.NR(NR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .plain_text(plain_text), .round_keys(round_keys), .out_valid(out_valid),
      .out_ready(out_ready), .cipher_text(cipher_text), .busy(busy),
      .round_cnt(round_cnt)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] sb [256];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   // Key is left-aligned in 256 bits; NR-6 words of it are used.
   function automatic logic [RKW-1:0] expand_key(input logic [255:0] key);
      logic [31:0]    w [60];
      logic [31:0]    t;
      logic [7:0]     rcon = 8'h01;
      logic [RKW-1:0] rk = '0;
      int             nk = NR - 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(NR+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]});
            t[31:24] = t[31:24] ^ rcon;
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= NR; r++)
         rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rk;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [RKW-1:0] rk);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] k, o;
      for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ rk[127-8*j -: 8];
      for (int r = 1; r <= NR; r++) begin
         k = rk[128*r +: 128];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               t[w+4*c] = sb[s[w+4*((c+w)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (r < NR) begin
               s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
               s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
            end else begin
               for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*c];
            end
         end
         for (int j = 0; j < 16; j++) s[j] = s[j] ^ k[127-8*j -: 8];
      end
      for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Entered at the negedge after the accept edge; lat counts edges since accept.
   task automatic wait_result(input bit toggle, inout int lat, inout bit rc_ok);
      while (!out_valid && lat < 40) begin
         if (toggle) begin
            in_valid   = 1'($urandom_range(0, 1));
            plain_text = rand128();
         end
         @(posedge clk); lat++;
         @(negedge clk);
         if (!out_valid && round_cnt != 4'(lat + 1)) rc_ok = 1'b0;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] pt, input bit toggle,
                            output logic [127:0] ct, output int lat, output bit rc_ok);
      int w = 0;
      in_valid   = 1'b1;
      plain_text = pt;
      while (!in_ready && w < 40) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      rc_ok    = (round_cnt == 4'd1);
      wait_result(toggle, lat, rc_ok);
      ct = cipher_text;
   endtask

   logic [127:0]   ct, exp, pt, ct1, last_ct;
   logic [RKW-1:0] rk;
   int             lat, got, idx, last, wait_n;
   bit             rc_ok, ok;
   logic [127:0]   blks [8];
   logic [127:0]   q [$];

   initial begin
      build_sbox();
      repeat (2) @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_cipher_text", cipher_text, 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_round_cnt", 128'(round_cnt), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS-197 App. B key/plaintext (key zero-padded for longer key sizes)
      round_keys = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      pt  = 128'h3243f6a8885a308d313198a2e0370734;
      exp = (NR == 10) ? 128'h3925841d02dc09fbdc118597196a0b32 : aes_model(pt, round_keys);
      run_block(pt, 1'b0, ct, lat, rc_ok);
      check("appB_ct", ct, exp);
      check("appB_latency", 128'(lat), 128'(NR));
      check("appB_round_cnt_steps", 128'(rc_ok), 128'd1);
      check("done_round_cnt", 128'(round_cnt), 128'd0);
      check("done_busy", 128'(busy), 128'd1);
      @(negedge clk);
      check("handshake_clears_valid", 128'(out_valid), 128'd0);
      check("idle_busy", 128'(busy), 128'd0);

      // FIPS-197 App. C
      round_keys = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      case (NR)
         12:      exp = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
         14:      exp = 128'h8ea2b7ca516745bfeafc49904b496089;
         default: exp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      endcase
      run_block(128'h00112233445566778899aabbccddeeff, 1'b0, ct, lat, rc_ok);
      check("appC_ct", ct, exp);
      check("appC_latency", 128'(lat), 128'(NR));
      @(negedge clk);

      // Back-pressure with a pending block, then same-edge handshake + accept
      rk = expand_key({rand128(), rand128()});
      round_keys = rk;
      out_ready  = 1'b0;
      pt = rand128();
      run_block(pt, 1'b0, ct1, lat, rc_ok);
      check("bp_first_ct", ct1, aes_model(pt, rk));
      pt = rand128();
      in_valid   = 1'b1;
      plain_text = pt;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (cipher_text !== ct1 || in_ready !== 1'b0 || out_valid !== 1'b1 || round_cnt !== 4'd0)
            ok = 1'b0;
      end
      check("bp_held_stable", 128'(ok), 128'd1);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_on_release", 128'(in_ready), 128'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_valid_dropped", 128'(out_valid), 128'd0);
      check("bp_new_accept", 128'(round_cnt), 128'd1);
      lat = 0;
      wait_result(1'b0, lat, rc_ok);
      check("bp_second_latency", 128'(lat), 128'(NR));
      check("bp_second_ct", cipher_text, aes_model(pt, rk));
      @(negedge clk);

      // Streaming: continuous in_valid and out_ready
      rk = expand_key({rand128(), rand128()});
      round_keys = rk;
      for (int i = 0; i < 8; i++) blks[i] = rand128();
      idx = 0; got = 0; last = -1; ok = 1'b1;
      for (int cyc = 0; cyc < 8*(NR+1) + 40 && got < 8; cyc++) begin
         if (idx < 8) begin in_valid = 1'b1; plain_text = blks[idx]; end
         else in_valid = 1'b0;
         #1;
         if (in_valid && in_ready) begin
            q.push_back(aes_model(blks[idx], rk));
            idx++;
         end
         if (out_valid && out_ready) begin
            if (q.size() > 0) check("stream_ct", cipher_text, q.pop_front());
            else check("stream_unexpected_result", 128'd1, 128'd0);
            if (last >= 0 && cyc - last != NR + 1) ok = 1'b0;
            last = cyc;
            got++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("stream_count", 128'(got), 128'd8);
      check("stream_period", 128'(ok), 128'd1);
      check("stream_queue_empty", 128'(q.size()), 128'd0);
      @(negedge clk);

      // Reset in the middle of a block
      last_ct    = cipher_text;
      in_valid   = 1'b1;
      plain_text = rand128();
      @(negedge clk);
      in_valid = 1'b0;
      wait_n = 0;
      while (round_cnt != 4'd5 && wait_n < 40) begin @(negedge clk); wait_n++; end
      check("mid_reset_reached_round5", 128'(round_cnt), 128'd5);
      rst_n = 1'b0;
      #1;
      check("mid_reset_out_valid", 128'(out_valid), 128'd0);
      check("mid_reset_cipher_text", cipher_text, 128'd0);
      check("mid_reset_in_ready", 128'(in_ready), 128'd1);
      check("mid_reset_round_cnt", 128'(round_cnt), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pt = rand128();
      run_block(pt, 1'b0, ct, lat, rc_ok);
      check("post_reset_ct", ct, aes_model(pt, rk));
      @(negedge clk);

      // Input toggled while rounds run must not disturb the accepted block
      for (int n = 0; n < 3; n++) begin
         pt = rand128();
         run_block(pt, 1'b1, ct, lat, rc_ok);
         check("ignored_input_ct", ct, aes_model(pt, rk));
         check("ignored_input_latency", 128'(lat), 128'(NR));
         @(negedge clk);
         check("ignored_input_no_accept", 128'(busy), 128'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
